training_wrr_arbiter: RTL and testbench
=======================================

Name: training_wrr_arbiter

Overview:
Parametrised next-generation arbiter for the training fabric. Selects one of W requestors per arbitration event in round-robin, strict-priority or weighted-round-robin mode. Supports a grant lock and a forced restart pointer. Grant is registered and one-hot; it drives the downstream mux select and the last-selection status bus.

Parameters:
W, 8, number of requestors (W >= 2)
CW, 4, width of each per-requestor weight field and of the credit counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
mode  in  2  0 = RR, 1 = SP, 2 = WRR, 3 = reserved (behaves as RR)
req  in  W  request vector, bit i = requestor i
weight  in  W*CW  per-requestor weight; field i = weight[i*CW +: CW]
arb  in  1  perform arbitration this cycle
lock  in  1  hold current grant; no re-arbitration
restart  in  1  force rotation pointer to restart_in
restart_in  in  W  restart pointer, one-hot expected
grant  out  W  registered one-hot grant, 0 = none
grant_valid  out  1  equals |grant
last  out  W  registered last non-zero grant (rotation pointer)

Behaviour:
- Reset (sampled on clk while reset = 1): grant = 0, grant_valid = 0, last = 0, credit = 0. Reset overrides all other inputs, including mid-WRR burst and lock.
- Latency: inputs sampled at edge N; grant valid after edge N; decision is combinational on req/mode/last/credit.
- Priority per cycle: reset > restart > lock > arb > hold.
- Restart: last <= restart_in reduced to its lowest set bit (0 if restart_in = 0); grant <= 0; credit <= 0. Same-cycle arb and lock are ignored.
- Lock = 1 with grant_valid = 1: grant, last and credit are held, even if req drops or arb = 1. Lock with grant_valid = 0 has no effect, and arb proceeds normally.
- arb = 0 (no lock, no restart): all state held.
- Rotation base index p:
  - p = index of last.
  - If last = 0, p = W-1, so the search starts at 0.
- RR: winner = first set req bit at indices p+1, p+2, ... with wrap modulo W, including p itself last.
- SP: winner = lowest set req bit; last still updates.
- WRR, winner selection:
  - If grant_valid and req[holder] = 1 and credit > 0: regrant holder, credit <= credit-1.
  - Otherwise pick the RR winner k; credit <= max(weight[k],1) - 1.
  - Weight 0 behaves as 1.
- Non-WRR modes: credit forced to 0.
- Mode change takes effect at the next arb. The first WRR arb after a switch always rotates.
- req = 0 on arb: grant <= 0, grant_valid <= 0, last and credit unchanged (credit cleared only in non-WRR modes).
- last <= grant whenever a non-zero grant is issued.
- Invariant: grant is one-hot or zero at all times.

Decomposition:
- Package training_arb_pkg:
  - mode enum (ARB_RR, ARB_SP, ARB_WRR, ARB_RSVD).
  - Default W and CW localparams.
  - Function onehot_lowest.
  - Function onehot_to_idx.
- Sub-module training_rr_pick:
  - Combinational rotating-priority one-hot picker with ports base[W], in[W], sp, select[W].
  - Implemented with the doubled-vector mask technique.
  - Used for both RR and SP.
- Top level holds the credit counter, lock/restart control and the grant/last registers.

Test Plan:
1. Reset, mode=RR, req=8'hFF, arb=1 for 4 cycles -> grant 01, 02, 04, 08; last tracks grant.
2. Wrap: last=8'h80, req=8'h81, arb twice -> grant 01 then 80.
3. SP: mode=1, req=8'hA4, arb for 3 cycles -> grant 04 each cycle, last=04.
4. WRR: weight0=3, weight1=1, req=8'h03, arb for 8 cycles -> grant 01,01,01,02,01,01,01,02. Drop req0 after its second grant -> immediate rotate to 02.
5. Restart+arb same cycle: restart_in=8'h08, req=FF -> grant 00, last 08; next arb -> grant 10. restart_in=8'h0C -> last 04.
6. Lock: grant=04, lock=1, req=00, arb=1 for 3 cycles -> grant 04 held. Release lock with arb=1 -> grant 00, grant_valid 0. Reset mid-WRR burst -> grant, last and credit all 0 next cycle.

Source files
------------

// File: rtl/training_wrr_arbiter_pkg.sv
// Shared types and one-hot helpers for the training fabric arbiter.
package training_arb_pkg;

  typedef enum logic [1:0] {
    ARB_RR   = 2'd0,
    ARB_SP   = 2'd1,
    ARB_WRR  = 2'd2,
    ARB_RSVD = 2'd3
  } arb_mode_e;

  localparam int unsigned DEF_W  = 8;
  localparam int unsigned DEF_CW = 4;
  // Helpers work on a fixed-width container; callers zero-extend W-bit vectors.
  localparam int unsigned MAX_W  = 64;

  function automatic logic [MAX_W-1:0] onehot_lowest(input logic [MAX_W-1:0] v);
    return v & (~v + MAX_W'(1));
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [MAX_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/training_wrr_arbiter_rr_pick.sv
// Combinational rotating-priority picker; the search starts just above base.
module training_rr_pick
  import training_arb_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic [W-1:0] base,
  input  logic [W-1:0] in,
  input  logic         sp,
  output logic [W-1:0] select
);

  logic [W-1:0]   base_eff;
  logic [W-1:0]   above;
  logic [W-1:0]   masked;
  logic [2*W-1:0] dbl;
  logic [2*W-1:0] dbl_low;

  always_comb begin
    base_eff = (base == '0) ? {1'b1, {(W-1){1'b0}}} : (base & (~base + W'(1)));
    above    = ~((base_eff << 1) - W'(1));
    masked   = in & above;
    // Lower half holds requests above base; upper half wraps back to index 0.
    dbl      = {in, masked};
    dbl_low  = dbl & (~dbl + (2*W)'(1));
    if (sp) select = in & (~in + W'(1));
    else    select = dbl_low[W-1:0] | dbl_low[2*W-1:W];
  end

endmodule

// File: rtl/training_wrr_arbiter.sv
// RR / SP / WRR arbiter with grant lock, forced restart pointer and registered one-hot grant.
module training_wrr_arbiter
  import training_arb_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  req,
  input  logic [W*CW-1:0] weight,
  input  logic          arb,
  input  logic          lock,
  input  logic          restart,
  input  logic [W-1:0]  restart_in,
  output logic [W-1:0]  grant,
  output logic          grant_valid,
  output logic [W-1:0]  last
);

  arb_mode_e       cur_mode;
  logic [CW-1:0]   credit;
  logic [W-1:0]    pick;
  logic [CW-1:0]   win_w;
  logic            hold_ok;
  logic [W-1:0]    next_grant;
  logic [CW-1:0]   next_credit;
  logic [W-1:0]    restart_low;

  training_rr_pick #(.W(W)) u_pick (
    .base   (last),
    .in     (req),
    .sp     (cur_mode == ARB_SP),
    .select (pick)
  );

  always_comb begin
    cur_mode    = arb_mode_e'(mode);
    restart_low = W'(onehot_lowest(MAX_W'(restart_in)));
    win_w       = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (pick[i]) win_w = weight[i*CW +: CW];
    end
    hold_ok     = grant_valid && ((req & grant) != '0) && (credit != '0);
    next_grant  = pick;
    next_credit = '0;
    if (cur_mode == ARB_WRR) begin
      if (hold_ok) begin
        next_grant  = grant;
        next_credit = credit - CW'(1);
      end else if (pick == '0) begin
        next_credit = credit;
      end else begin
        // Weight 0 is treated as 1: a single grant with no extra credit.
        next_credit = (win_w == '0) ? '0 : win_w - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      last        <= '0;
      credit      <= '0;
    end else if (restart) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      last        <= restart_low;
      credit      <= '0;
    end else if (lock && grant_valid) begin
      grant       <= grant;
      grant_valid <= grant_valid;
      last        <= last;
      credit      <= credit;
    end else if (arb) begin
      grant       <= next_grant;
      grant_valid <= (next_grant != '0);
      if (next_grant != '0) last <= next_grant;
      credit      <= next_credit;
    end
  end

endmodule

// File: tb/tb_training_wrr_arbiter.sv
// Scoreboard bench: directed vectors push expectations, a negedge monitor pops and compares.
module tb_training_wrr_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  mode;
  logic [7:0]  req;
  logic [31:0] weight;
  logic        arb;
  logic        lock;
  logic        restart;
  logic [7:0]  restart_in;
  logic [7:0]  grant;
  logic        grant_valid;
  logic [7:0]  last;

  typedef struct {
    string      name;
    logic [7:0] g;
    logic [7:0] l;
    logic       chk_c;
    logic [3:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  training_wrr_arbiter #(.W(8), .CW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .req         (req),
    .weight      (weight),
    .arb         (arb),
    .lock        (lock),
    .restart     (restart),
    .restart_in  (restart_in),
    .grant       (grant),
    .grant_valid (grant_valid),
    .last        (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic rst, input logic [1:0] md, input logic [7:0] rq,
                       input logic ar, input logic lk, input logic rs, input logic [7:0] rsin,
                       input logic [7:0] eg, input logic [7:0] el, input string nm,
                       input logic cc = 1'b0, input logic [3:0] ec = 4'd0);
    exp_t e;
    reset = rst; mode = md; req = rq; arb = ar; lock = lk; restart = rs; restart_in = rsin;
    @(posedge clk);
    e.name = nm; e.g = eg; e.l = el; e.chk_c = cc; e.c = ec;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g) begin
        errors++;
        $display("FAIL %s grant: got %02h expected %02h", e.name, grant, e.g);
      end
      checks++;
      if (grant_valid !== (e.g != 8'h00)) begin
        errors++;
        $display("FAIL %s grant_valid: got %0b expected %0b", e.name, grant_valid, (e.g != 8'h00));
      end
      checks++;
      if (last !== e.l) begin
        errors++;
        $display("FAIL %s last: got %02h expected %02h", e.name, last, e.l);
      end
      if (e.chk_c) begin
        checks++;
        if (dut.credit !== e.c) begin
          errors++;
          $display("FAIL %s credit: got %0d expected %0d", e.name, dut.credit, e.c);
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; mode = 2'd0; req = '0; weight = '0; arb = 1'b0;
    lock = 1'b0; restart = 1'b0; restart_in = '0;
    @(negedge clk);

    // 1: RR from reset
    apply(1, 0, 8'hFF, 1, 1, 1, 8'h10, 8'h00, 8'h00, "t1_reset", 1, 0);
    apply(0, 0, 8'hFF, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t1_rr0");
    apply(0, 0, 8'hFF, 1, 0, 0, 8'h00, 8'h02, 8'h02, "t1_rr1");
    apply(0, 0, 8'hFF, 1, 0, 0, 8'h00, 8'h04, 8'h04, "t1_rr2");
    apply(0, 0, 8'hFF, 1, 0, 0, 8'h00, 8'h08, 8'h08, "t1_rr3");
    apply(0, 0, 8'hFF, 0, 0, 0, 8'h00, 8'h08, 8'h08, "t1_hold");

    // 2: wrap from last = 80
    apply(0, 0, 8'h81, 0, 0, 1, 8'h80, 8'h00, 8'h80, "t2_restart");
    apply(0, 0, 8'h81, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t2_wrap");
    apply(0, 0, 8'h81, 1, 0, 0, 8'h00, 8'h80, 8'h80, "t2_next");

    // 3: strict priority
    apply(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, "t3_reset");
    for (int i = 0; i < 3; i++)
      apply(0, 1, 8'hA4, 1, 0, 0, 8'h00, 8'h04, 8'h04, "t3_sp", 1, 0);

    // 3b: reserved mode behaves as RR
    apply(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, "t3b_reset");
    apply(0, 3, 8'hFF, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t3b_rsvd0");
    apply(0, 3, 8'hFF, 1, 0, 0, 8'h00, 8'h02, 8'h02, "t3b_rsvd1");

    // 4: WRR weight0=3 weight1=1
    weight = 32'h0000_0013;
    apply(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, "t4_reset");
    apply(0, 2, 8'h03, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t4_w0", 1, 2);
    apply(0, 2, 8'h03, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t4_w1", 1, 1);
    apply(0, 2, 8'h03, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t4_w2", 1, 0);
    apply(0, 2, 8'h03, 1, 0, 0, 8'h00, 8'h02, 8'h02, "t4_w3", 1, 0);
    apply(0, 2, 8'h03, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t4_w4");
    apply(0, 2, 8'h03, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t4_w5");
    apply(0, 2, 8'h03, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t4_w6");
    apply(0, 2, 8'h03, 1, 0, 0, 8'h00, 8'h02, 8'h02, "t4_w7");
    apply(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, "t4_reset2");
    apply(0, 2, 8'h03, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t4_d0");
    apply(0, 2, 8'h03, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t4_d1", 1, 1);
    apply(0, 2, 8'h02, 1, 0, 0, 8'h00, 8'h02, 8'h02, "t4_drop", 1, 0);
    apply(0, 2, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h02, "t4_noreq", 1, 0);

    // 5: restart beats arb and lock
    weight = '0;
    apply(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, "t5_reset");
    apply(0, 0, 8'hFF, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t5_pre");
    apply(0, 0, 8'hFF, 1, 1, 1, 8'h08, 8'h00, 8'h08, "t5_restart", 1, 0);
    apply(0, 0, 8'hFF, 1, 0, 0, 8'h00, 8'h10, 8'h10, "t5_after");
    apply(0, 0, 8'hFF, 0, 0, 1, 8'h0C, 8'h00, 8'h04, "t5_multi");
    apply(0, 0, 8'hFF, 0, 0, 1, 8'h00, 8'h00, 8'h00, "t5_zero");

    // 6: lock hold, release, reset mid-WRR burst
    apply(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, "t6_reset");
    apply(0, 0, 8'h00, 1, 1, 0, 8'h00, 8'h00, 8'h00, "t6_lock_idle");
    apply(0, 0, 8'h04, 1, 0, 0, 8'h00, 8'h04, 8'h04, "t6_grant");
    for (int i = 0; i < 3; i++)
      apply(0, 0, 8'h00, 1, 1, 0, 8'h00, 8'h04, 8'h04, "t6_locked");
    apply(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h04, "t6_release");
    weight = 32'h0000_0003;
    apply(0, 2, 8'h01, 1, 0, 0, 8'h00, 8'h01, 8'h01, "t6_wrr", 1, 2);
    apply(1, 2, 8'h01, 1, 1, 0, 8'h00, 8'h00, 8'h00, "t6_reset_burst", 1, 0);

    reset = 1'b0; arb = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
